crossfade_sequencer: RTL and testbench

CROSSFADE_SEQUENCER -- requirements
Module: crossfade_sequencer

---
 rtl/crossfade_sequencer.sv | 167 ++++++++++++++++
 tb/tb_crossfade_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crossfade_sequencer.sv
// Crossfade sequencer: steps alpha between src_index and dst_index once per frame_tick, commits, and can auto-advance.
// Latency: an accepted request loads dst_index/alpha on the next edge. Alpha then moves by STEP per frame_tick. COMMIT lasts one cycle.
// Backpressure: req_ready drops only while the single pending slot is full. A request offered then is not taken.
// Ports: clk/rst (async, active-high); frame_tick; req_valid/req_index/req_ready request handshake;
//        auto_en slideshow enable; src_index/dst_index/alpha blend controls; busy (state != IDLE); done commit pulse.
module crossfade_sequencer #(
    parameter int STEP         = 8,
    parameter int DWELL_FRAMES = 120,
    parameter int NUM_IMAGES   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       req_valid,
    input  logic [3:0] req_index,
    output logic       req_ready,
    input  logic       auto_en,
    output logic [3:0] src_index,
    output logic [3:0] dst_index,
    output logic [7:0] alpha,
    output logic       busy,
    output logic       done
);
    localparam int              DWELL_W    = (DWELL_FRAMES < 2) ? 1 : $clog2(DWELL_FRAMES);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_FRAMES - 1);
    localparam logic [3:0]      LAST_IMG   = 4'(NUM_IMAGES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FADE   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           src_q, src_d;
    logic [3:0]           dst_q, dst_d;
    logic [7:0]           alpha_q, alpha_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 ready_q, ready_d;
    logic                 pend_vld_q, pend_vld_d;
    logic [3:0]           pend_idx_q, pend_idx_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;

    logic                 req_acc;
    logic [8:0]           alpha_sum;
    logic                 have_next;
    logic [3:0]           next_idx;

    assign req_acc   = req_valid & ready_q;
    // Nine-bit sum so the "would reach 255" test can never wrap.
    assign alpha_sum = {1'b0, alpha_q} + 9'(STEP);

    function automatic logic target_ok(input logic [3:0] idx, input logic [3:0] cur);
        return (idx != cur) && ({1'b0, idx} < 5'(NUM_IMAGES));
    endfunction

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        alpha_d    = alpha_q;
        done_d     = 1'b0;
        pend_vld_d = pend_vld_q;
        pend_idx_d = pend_idx_q;
        dwell_d    = dwell_q;
        have_next  = 1'b0;
        next_idx   = 4'd0;

        case (state_q)
            ST_IDLE: begin
                // A request that starts a fade beats the slideshow.
                // A rejected request is simply dropped and leaves auto mode untouched.
                if (req_acc && target_ok(req_index, src_q)) begin
                    dst_d   = req_index;
                    alpha_d = 8'd0;
                    dwell_d = '0;
                    state_d = ST_FADE;
                end else if (!auto_en) begin
                    dwell_d = '0;
                end else if (frame_tick) begin
                    if (dwell_q == DWELL_LAST) begin
                        dst_d   = (src_q == LAST_IMG) ? 4'd0 : src_q + 4'd1;
                        alpha_d = 8'd0;
                        dwell_d = '0;
                        state_d = ST_FADE;
                    end else begin
                        dwell_d = dwell_q + DWELL_W'(1);
                    end
                end
            end

            ST_FADE: begin
                dwell_d = '0;
                if (req_acc) begin
                    pend_vld_d = 1'b1;
                    pend_idx_d = req_index;
                end
                if (frame_tick) begin
                    if (alpha_sum >= 9'd255) begin
                        alpha_d = 8'hFF;
                        state_d = ST_COMMIT;
                    end else begin
                        alpha_d = alpha_sum[7:0];
                    end
                end
            end

            ST_COMMIT: begin
                dwell_d = '0;
                src_d   = dst_q;
                alpha_d = 8'd0;
                done_d  = 1'b1;
                // A request accepted during this very cycle counts as pending.
                have_next  = pend_vld_q | req_acc;
                next_idx   = pend_vld_q ? pend_idx_q : req_index;
                pend_vld_d = 1'b0;
                if (have_next && target_ok(next_idx, dst_q)) begin
                    dst_d   = next_idx;
                    state_d = ST_FADE;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = ~pend_vld_d;
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            src_q      <= 4'd0;
            dst_q      <= 4'd0;
            alpha_q    <= 8'd0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
            pend_vld_q <= 1'b0;
            pend_idx_q <= 4'd0;
            dwell_q    <= '0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            alpha_q    <= alpha_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            pend_vld_q <= pend_vld_d;
            pend_idx_q <= pend_idx_d;
            dwell_q    <= dwell_d;
        end
    end

    assign req_ready = ready_q;
    assign src_index = src_q;
    assign dst_index = dst_q;
    assign alpha     = alpha_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule

// File: tb/tb_crossfade_sequencer.sv
// Bench for crossfade_sequencer: two instances (STEP=64/NUM_IMAGES=8/DWELL=3 and STEP=255/NUM_IMAGES=16/DWELL=5)
// share one stimulus stream. Each is compared every cycle against its own behavioural model.
// Directed scenarios add literal expectations. A randomized phase follows them.
module tb_crossfade_sequencer;
    localparam int PH_IDLE = 0, PH_FADE = 1, PH_COMMIT = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       req_valid = 1'b0;
    logic [3:0] req_index = 4'd0;
    logic       auto_en = 1'b0;

    logic       a_ready, a_busy, a_done, b_ready, b_busy, b_done;
    logic [3:0] a_src, a_dst, b_src, b_dst;
    logic [7:0] a_alpha, b_alpha;

    int checks = 0;
    int errors = 0;

    // Model state, one slot per instance
    int p_step[2], p_dwell[2], p_n[2];
    int m_src[2], m_dst[2], m_alpha[2], m_done[2], m_ready[2];
    int m_phase[2], m_pv[2], m_pi[2], m_dwell[2];

    always #5 clk = ~clk;

    crossfade_sequencer #(.STEP(64), .DWELL_FRAMES(3), .NUM_IMAGES(8)) dut_a (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .req_valid(req_valid),
        .req_index(req_index), .req_ready(a_ready), .auto_en(auto_en),
        .src_index(a_src), .dst_index(a_dst), .alpha(a_alpha), .busy(a_busy), .done(a_done)
    );

    crossfade_sequencer #(.STEP(255), .DWELL_FRAMES(5), .NUM_IMAGES(16)) dut_b (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .req_valid(req_valid),
        .req_index(req_index), .req_ready(b_ready), .auto_en(auto_en),
        .src_index(b_src), .dst_index(b_dst), .alpha(b_alpha), .busy(b_busy), .done(b_done)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int k);
        m_src[k] = 0; m_dst[k] = 0; m_alpha[k] = 0; m_done[k] = 0; m_ready[k] = 1;
        m_phase[k] = PH_IDLE; m_pv[k] = 0; m_pi[k] = 0; m_dwell[k] = 0;
    endtask

    function automatic bit target_ok(input int k, input int idx, input int cur);
        return (idx != cur) && (idx < p_n[k]);
    endfunction

    task automatic start_fade(input int k, input int idx);
        m_dst[k] = idx; m_alpha[k] = 0; m_phase[k] = PH_FADE; m_dwell[k] = 0;
    endtask

    // One clock of the sequencer's rules, given the inputs seen at the edge
    task automatic model_step(input int k, input bit t, input bit v, input int idx, input bit au);
        bit acc;
        bit have_p;
        int p;
        acc = v && (m_ready[k] != 0);
        m_done[k] = 0;
        if (m_phase[k] == PH_IDLE) begin
            if (acc && target_ok(k, idx, m_src[k])) start_fade(k, idx);
            else if (!au) m_dwell[k] = 0;
            else if (t) begin
                if (m_dwell[k] + 1 == p_dwell[k]) start_fade(k, (m_src[k] + 1) % p_n[k]);
                else m_dwell[k] = m_dwell[k] + 1;
            end
        end else if (m_phase[k] == PH_FADE) begin
            m_dwell[k] = 0;
            if (acc) begin m_pv[k] = 1; m_pi[k] = idx; end
            if (t) begin
                if (m_alpha[k] + p_step[k] >= 255) begin
                    m_alpha[k] = 255; m_phase[k] = PH_COMMIT;
                end else begin
                    m_alpha[k] = m_alpha[k] + p_step[k];
                end
            end
        end else begin
            m_dwell[k] = 0;
            m_src[k] = m_dst[k];
            m_alpha[k] = 0;
            m_done[k] = 1;
            have_p = (m_pv[k] != 0) || acc;
            p = (m_pv[k] != 0) ? m_pi[k] : idx;
            m_pv[k] = 0;
            if (have_p && target_ok(k, p, m_src[k])) begin
                m_dst[k] = p; m_phase[k] = PH_FADE;
            end else begin
                m_phase[k] = PH_IDLE;
            end
        end
        m_ready[k] = (m_pv[k] == 0) ? 1 : 0;
    endtask

    task automatic cmp_inst(input int k, input string tag, input logic [3:0] s, input logic [3:0] d,
                            input logic [7:0] a, input logic b, input logic dn, input logic r);
        chk({tag, ".src_index"}, int'(s), m_src[k]);
        chk({tag, ".dst_index"}, int'(d), m_dst[k]);
        chk({tag, ".alpha"}, int'(a), m_alpha[k]);
        chk({tag, ".busy"}, int'(b), (m_phase[k] != PH_IDLE) ? 1 : 0);
        chk({tag, ".done"}, int'(dn), m_done[k]);
        chk({tag, ".req_ready"}, int'(r), m_ready[k]);
    endtask

    // Model update on every rising edge, comparison on every falling edge
    initial begin
        p_step[0] = 64;  p_dwell[0] = 3; p_n[0] = 8;
        p_step[1] = 255; p_dwell[1] = 5; p_n[1] = 16;
        model_reset(0);
        model_reset(1);
        forever begin
            @(posedge clk);
            if (rst) begin
                model_reset(0);
                model_reset(1);
            end else begin
                model_step(0, frame_tick, req_valid, int'(req_index), auto_en);
                model_step(1, frame_tick, req_valid, int'(req_index), auto_en);
            end
            @(negedge clk);
            cmp_inst(0, "A", a_src, a_dst, a_alpha, a_busy, a_done, a_ready);
            cmp_inst(1, "B", b_src, b_dst, b_alpha, b_busy, b_done, b_ready);
        end
    end

    task automatic step(input bit t, input bit v, input int idx, input bit au);
        @(negedge clk); #1;
        frame_tick = t; req_valid = v; req_index = 4'(idx); auto_en = au;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rst = 1'b1; frame_tick = 1'b0; req_valid = 1'b0; auto_en = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic reach_src7();
        do_reset();
        step(0, 1, 7, 0);
        repeat (4) step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        chk("auto.src_start", int'(a_src), 7);
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        chk("auto.still_idle", int'(a_busy), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        @(posedge clk); #1;
        chk("rst.src", int'(a_src), 0);
        chk("rst.alpha", int'(a_alpha), 0);
        chk("rst.ready", int'(a_ready), 1);
        chk("rst.busy", int'(a_busy), 0);
        chk("rst.done", int'(b_done), 0);
        @(negedge clk); #1;
        rst = 1'b0;

        // S1: STEP=64 fade 0 -> 5. A tick in the accept cycle is ignored. B (STEP=255) commits on the first tick.
        step(1, 1, 5, 0);
        chk("s1.dst", int'(a_dst), 5);
        chk("s1.alpha0", int'(a_alpha), 0);
        chk("s1.busy", int'(a_busy), 1);
        chk("s1.b_alpha0", int'(b_alpha), 0);
        step(1, 0, 0, 0);
        chk("s1.alpha64", int'(a_alpha), 64);
        chk("s1.model_alpha64", m_alpha[0], 64);
        chk("s1.b_alpha255", int'(b_alpha), 255);
        chk("s1.b_busy", int'(b_busy), 1);
        step(1, 0, 0, 0);
        chk("s1.alpha128", int'(a_alpha), 128);
        chk("s1.b_src", int'(b_src), 5);
        chk("s1.b_done", int'(b_done), 1);
        chk("s1.b_idle", int'(b_busy), 0);
        step(1, 0, 0, 0);
        chk("s1.alpha192", int'(a_alpha), 192);
        step(1, 0, 0, 0);
        chk("s1.alpha255", int'(a_alpha), 255);
        chk("s1.commit_busy", int'(a_busy), 1);
        chk("s1.no_done_yet", int'(a_done), 0);
        step(0, 0, 0, 0);
        chk("s1.src5", int'(a_src), 5);
        chk("s1.alpha_clr", int'(a_alpha), 0);
        chk("s1.done", int'(a_done), 1);
        chk("s1.idle", int'(a_busy), 0);
        chk("s1.model_src5", m_src[0], 5);
        step(0, 0, 0, 0);
        chk("s1.done_pulse", int'(a_done), 0);

        // S2: pending slot holds 3, request 7 refused, commit to 5 chains straight into fade to 3
        do_reset();
        step(0, 1, 5, 0);
        step(0, 1, 3, 0);
        chk("s2.ready_low", int'(a_ready), 0);
        step(0, 1, 7, 0);
        chk("s2.ready_still_low", int'(a_ready), 0);
        chk("s2.dst_kept", int'(a_dst), 5);
        repeat (4) step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("s2.src5", int'(a_src), 5);
        chk("s2.done", int'(a_done), 1);
        chk("s2.chain_busy", int'(a_busy), 1);
        chk("s2.chain_dst3", int'(a_dst), 3);
        chk("s2.ready_back", int'(a_ready), 1);
        repeat (4) step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("s2.src3", int'(a_src), 3);
        chk("s2.idle", int'(a_busy), 0);

        // S3: request equal to src, and an index beyond NUM_IMAGES=8
        step(0, 1, 3, 0);
        chk("s3.same_busy", int'(a_busy), 0);
        chk("s3.same_done", int'(a_done), 0);
        step(0, 1, 12, 0);
        chk("s3.big_busy", int'(a_busy), 0);
        chk("s3.big_dst", int'(a_dst), 3);
        chk("s3.big_done", int'(a_done), 0);

        // S4: auto-advance wraps 7 -> 0 on third dwell tick. An external request on that tick wins.
        reach_src7();
        step(1, 0, 0, 1);
        chk("s4.auto_busy", int'(a_busy), 1);
        chk("s4.auto_dst0", int'(a_dst), 0);
        reach_src7();
        step(1, 1, 4, 1);
        chk("s4.ext_busy", int'(a_busy), 1);
        chk("s4.ext_dst4", int'(a_dst), 4);

        // S5: asynchronous reset at alpha=128, then a fresh fade
        do_reset();
        step(0, 1, 5, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("s5.alpha128", int'(a_alpha), 128);
        @(negedge clk); #1;
        rst = 1'b1; frame_tick = 1'b0; req_valid = 1'b0;
        #1;
        chk("s5.rst_alpha", int'(a_alpha), 0);
        chk("s5.rst_busy", int'(a_busy), 0);
        chk("s5.rst_dst", int'(a_dst), 0);
        chk("s5.rst_ready", int'(a_ready), 1);
        chk("s5.rst_done", int'(a_done), 0);
        @(posedge clk); #1;
        @(negedge clk); #1;
        rst = 1'b0;
        step(0, 1, 2, 0);
        chk("s5.fresh_dst", int'(a_dst), 2);
        chk("s5.fresh_alpha", int'(a_alpha), 0);
        step(1, 0, 0, 0);
        chk("s5.fresh_alpha64", int'(a_alpha), 64);

        // Randomized phase: every-cycle model comparison does the checking
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            rst        = ($urandom_range(0, 249) == 0);
            frame_tick = ($urandom_range(0, 2) == 0);
            req_valid  = ($urandom_range(0, 3) == 0);
            req_index  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0) auto_en = ~auto_en;
            @(posedge clk);
        end
        @(negedge clk); #1;
        rst = 1'b0; req_valid = 1'b0; frame_tick = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
